// File: rtl/alu_cmd_sequencer.sv
// Clocked front end for a combinational ALU: registers operands and select, waits a
// settle window, then captures the ALU result into a first-word fall-through response FIFO.
module alu_cmd_sequencer #(
    parameter int WIDTH     = 8,
    parameter int SEL_W     = 4,
    parameter int SETTLE    = 1,
    parameter int RSP_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [WIDTH-1:0]   cmd_a,
    input  logic [WIDTH-1:0]   cmd_b,
    input  logic [SEL_W-1:0]   cmd_sel,
    output logic [WIDTH-1:0]   alu_a,
    output logic [WIDTH-1:0]   alu_b,
    output logic [SEL_W-1:0]   alu_sel,
    input  logic [WIDTH-1:0]   alu_out,
    input  logic               alu_carry,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [WIDTH-1:0]   rsp_result,
    output logic               rsp_carry,
    output logic [SEL_W-1:0]   rsp_sel,
    output logic               busy,
    output logic [15:0]        op_count
);

    localparam int PTR_W  = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int CNT_W  = PTR_W + 1;
    localparam int SCNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam int ENT_W  = SEL_W + 1 + WIDTH;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(RSP_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_CAPTURE
    } state_e;

    state_e             state_q, state_d;
    logic [SCNT_W-1:0]  settle_q, settle_d;
    logic [WIDTH-1:0]   alu_a_q, alu_a_d;
    logic [WIDTH-1:0]   alu_b_q, alu_b_d;
    logic [SEL_W-1:0]   alu_sel_q, alu_sel_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [ENT_W-1:0]   head_q, head_d;
    logic [15:0]        op_count_q, op_count_d;
    logic [ENT_W-1:0]   mem [RSP_DEPTH];

    logic               push;
    logic               pop;
    logic [ENT_W-1:0]   push_data;

    assign push      = (state_q == S_CAPTURE);
    assign pop       = (count_q != '0) && rsp_ready;
    assign push_data = {alu_sel_q, alu_carry, alu_out};

    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        settle_d   = settle_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_sel_d  = alu_sel_q;
        op_count_d = op_count_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        head_d     = head_q;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid && (count_q < DEPTH_C)) begin
                    alu_a_d   = cmd_a;
                    alu_b_d   = cmd_b;
                    alu_sel_d = cmd_sel;
                    settle_d  = SCNT_W'(SETTLE - 1);
                    state_d   = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (settle_q == '0) state_d = S_CAPTURE;
                else                settle_d = settle_q - 1'b1;
            end
            S_CAPTURE: begin
                op_count_d = op_count_q + 16'd1;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (push && !pop)      count_d = count_q + 1'b1;
        else if (pop && !push) count_d = count_q - 1'b1;

        // Head register follows the next read slot, bypassing a same-edge write; holds when empty.
        if (count_d != '0) begin
            if (push && (wr_ptr_q == rd_ptr_d)) head_d = push_data;
            else                                head_d = mem[rd_ptr_d];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            settle_q   <= '0;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_sel_q  <= '0;
            op_count_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            head_q     <= '0;
        end else begin
            state_q    <= state_d;
            settle_q   <= settle_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_sel_q  <= alu_sel_d;
            op_count_q <= op_count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            head_q     <= head_d;
        end
    end

    // NOTE: storage is not reset; the pointers and count define which entries are meaningful.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= push_data;
    end

    assign cmd_ready  = (state_q == S_IDLE) && (count_q < DEPTH_C);
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_sel    = alu_sel_q;
    assign rsp_valid  = (count_q != '0);
    assign rsp_result = head_q[WIDTH-1:0];
    assign rsp_carry  = head_q[WIDTH];
    assign rsp_sel    = head_q[ENT_W-1 -: SEL_W];
    assign busy       = (state_q != S_IDLE);
    assign op_count   = op_count_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Scoreboard bench for alu_cmd_sequencer: a slow-settling ALU stub, directed scenarios
// and randomized traffic, with responses checked in order against an arithmetic reference.
module tb_alu_cmd_sequencer;

    localparam int WIDTH     = 8;
    localparam int SEL_W     = 4;
    localparam int SETTLE    = 1;
    localparam int RSP_DEPTH = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [7:0]       cmd_a, cmd_b;
    logic [3:0]       cmd_sel;
    logic [7:0]       alu_a, alu_b;
    logic [3:0]       alu_sel;
    logic [7:0]       alu_out;
    logic             alu_carry;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [7:0]       rsp_result;
    logic             rsp_carry;
    logic [3:0]       rsp_sel;
    logic             busy;
    logic [15:0]      op_count;

    alu_cmd_sequencer #(
        .WIDTH(WIDTH), .SEL_W(SEL_W), .SETTLE(SETTLE), .RSP_DEPTH(RSP_DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_sel(cmd_sel),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
        .alu_out(alu_out), .alu_carry(alu_carry),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_carry(rsp_carry), .rsp_sel(rsp_sel),
        .busy(busy), .op_count(op_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] sel;
        logic       carry;
        logic [7:0] result;
    } rsp_t;

    rsp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   accepted = 0;
    bit   stream_chk = 0;

    // Reference ALU: carry is the carry out of A+B for every select; result by plain arithmetic.
    function automatic logic [8:0] alu_ref(input int a, input int b, input int sel);
        int r;
        case (sel)
            0:  r = (a + b) % 256;
            1:  r = (a - b + 256) % 256;
            2:  r = (a * b) % 256;
            3:  r = (b == 0) ? 0 : a / b;
            4:  r = (a * 2) % 256;
            5:  r = a / 2;
            6:  r = (a * 2) % 256 + a / 128;
            7:  r = a / 2 + (a % 2) * 128;
            8:  r = a & b;
            9:  r = a | b;
            10: r = a ^ b;
            11: r = 255 - (a | b);
            12: r = 255 - (a & b);
            13: r = 255 - (a ^ b);
            14: r = (a > b) ? 1 : 0;
            default: r = (a == b) ? 1 : 0;
        endcase
        return {((a + b) > 255) ? 1'b1 : 1'b0, r[7:0]};
    endfunction

    // ALU stub that shows inverted garbage until its inputs have been stable long enough.
    int unsigned neg_cyc = 0;
    int unsigned chg_cyc = 0;
    always @(negedge clk) neg_cyc++;
    always @(alu_a or alu_b or alu_sel) chg_cyc = neg_cyc;
    always_comb begin
        logic [8:0] v;
        v = alu_ref(alu_a, alu_b, alu_sel);
        if ((neg_cyc - chg_cyc) >= SETTLE + 1) {alu_carry, alu_out} = v;
        else                                   {alu_carry, alu_out} = ~v;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Monitor: both handshakes seen here complete at the following rising edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_rsp", 32'(rsp_result), 32'hFFFF_FFFF);
                end else begin
                    rsp_t e;
                    e = exp_q.pop_front();
                    check("rsp_result", 32'(rsp_result), 32'(e.result));
                    check("rsp_carry", 32'(rsp_carry), 32'(e.carry));
                    check("rsp_sel", 32'(rsp_sel), 32'(e.sel));
                end
            end
            if (cmd_valid && cmd_ready) begin
                rsp_t e;
                logic [8:0] v;
                v = alu_ref(cmd_a, cmd_b, cmd_sel);
                e.sel = cmd_sel;
                e.carry = v[8];
                e.result = v[7:0];
                exp_q.push_back(e);
                accepted++;
            end
            if (stream_chk && !busy) check("stream_cmd_ready", 32'(cmd_ready), 32'd1);
        end
    end

    task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [3:0] sel);
        bit ok;
        ok = 0;
        cmd_a = a; cmd_b = b; cmd_sel = sel; cmd_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (cmd_ready) begin ok = 1; break; end
        end
        if (!ok) check("issue_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_drain();
        bit ok;
        ok = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !busy && !rsp_valid) begin ok = 1; break; end
        end
        if (!ok) check("drain_timeout", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0;
        cmd_a = '0; cmd_b = '0; cmd_sel = '0;
        #23 rst_n = 1'b1;
        @(negedge clk);
        check("rst_alu_a", 32'(alu_a), 32'd0);
        check("rst_alu_b", 32'(alu_b), 32'd0);
        check("rst_alu_sel", 32'(alu_sel), 32'd0);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_op_count", 32'(op_count), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;

        // Add with carry plus latency: handshake at edge k, response visible after edge k+2.
        issue(8'hFF, 8'h01, 4'b0000);
        @(negedge clk);
        check("lat_k_valid", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        check("lat_k1_valid", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        check("lat_k2_valid", 32'(rsp_valid), 32'd1);
        check("add_op_count", 32'(op_count), 32'd1);
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        wait_drain();

        // Rotate left; operands persist and the empty FIFO holds its last head.
        issue(8'h0A, 8'h05, 4'b0110);
        wait_drain();
        repeat (2) @(negedge clk);
        check("rotl_alu_a_hold", 32'(alu_a), 32'h0A);
        check("empty_hold_result", 32'(rsp_result), 32'h14);
        check("empty_hold_sel", 32'(rsp_sel), 32'h6);
        check("empty_valid", 32'(rsp_valid), 32'd0);
        @(posedge clk); #1;

        // Backpressure: four fill the FIFO, the fifth waits for one pop.
        rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) issue(8'(8'h10 + i), 8'(8'h20 + 3 * i), 4'(i));
        cmd_a = 8'h77; cmd_b = 8'h99; cmd_sel = 4'hA; cmd_valid = 1'b1;
        repeat (8) @(negedge clk);
        check("full_cmd_ready", 32'(cmd_ready), 32'd0);
        check("full_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        check("full_pre_pop_ready", 32'(cmd_ready), 32'd0);
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        @(negedge clk);
        check("post_pop_ready", 32'(cmd_ready), 32'd1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        wait_drain();
        check("bp_op_count", 32'(op_count), 32'(accepted));

        // Streaming at full rate with the consumer always ready.
        stream_chk = 1;
        for (int i = 0; i < 20; i++) issue(8'($urandom), 8'($urandom), 4'($urandom));
        wait_drain();
        stream_chk = 0;
        check("stream_op_count", 32'(op_count), 32'(accepted));

        // Reset while a third command settles behind two queued responses.
        rsp_ready = 1'b0;
        issue(8'h01, 8'h02, 4'h0);
        issue(8'h03, 8'h04, 4'h1);
        issue(8'h05, 8'h06, 4'h2);
        check("mid_busy", 32'(busy), 32'd1);
        check("mid_valid", 32'(rsp_valid), 32'd1);
        rst_n = 1'b0;
        exp_q.delete();
        accepted = 0;
        #1;
        check("mid_rst_valid", 32'(rsp_valid), 32'd0);
        #6 rst_n = 1'b1;
        rsp_ready = 1'b1;
        @(negedge clk);
        check("mid_op_count", 32'(op_count), 32'd0);
        check("mid_alu_a", 32'(alu_a), 32'd0);
        check("mid_alu_b", 32'(alu_b), 32'd0);
        check("mid_alu_sel", 32'(alu_sel), 32'd0);
        repeat (6) @(negedge clk);
        check("mid_no_stale", 32'(rsp_valid), 32'd0);
        @(posedge clk); #1;

        // Randomized traffic with a randomly stalling consumer.
        begin
            bit done;
            done = 0;
            fork
                begin
                    for (int i = 0; i < 40; i++) issue(8'($urandom), 8'($urandom), 4'($urandom));
                    done = 1;
                end
                begin
                    for (int i = 0; i < 5000 && !done; i++) begin
                        @(posedge clk); #1;
                        rsp_ready = 1'($urandom_range(0, 1));
                    end
                end
            join
        end
        rsp_ready = 1'b1;
        wait_drain();
        check("rand_op_count", 32'(op_count), 32'(accepted));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
- Sequential front end for the combinational ALU (operands A/B, select ALU_Sel, result ALU_Out and CarryOut).
- Accepts operation commands over a valid/ready handshake and drives the ALU operand and select inputs from registers.
- Holds those inputs stable for a settle window, then captures ALU_Out/CarryOut into a response FIFO drained over a second valid/ready handshake.
- Lets clocked benches and upstream logic use the ALU without timing races.

Parameters:
- WIDTH, 8: operand and result width.
- SEL_W, 4: ALU select width.
- SETTLE, 1: cycles the operands are held before capture; must be 1 or more.
- RSP_DEPTH, 4: response FIFO depth; must be a power of two, 2 or more.

Ports:
- clk  in  1: system clock, rising edge.
- rst_n  in  1: asynchronous active-low reset.
- cmd_valid  in  1: command present.
- cmd_ready  out  1: sequencer can accept a command.
- cmd_a  in  WIDTH: operand A.
- cmd_b  in  WIDTH: operand B.
- cmd_sel  in  SEL_W: ALU operation select.
- alu_a  out  WIDTH: registered operand to ALU A.
- alu_b  out  WIDTH: registered operand to ALU B.
- alu_sel  out  SEL_W: registered select to ALU_Sel.
- alu_out  in  WIDTH: ALU_Out from the ALU.
- alu_carry  in  1: CarryOut from the ALU.
- rsp_valid  out  1: response available at FIFO head.
- rsp_ready  in  1: consumer takes the response.
- rsp_result  out  WIDTH: captured ALU_Out.
- rsp_carry  out  1: captured CarryOut.
- rsp_sel  out  SEL_W: select that produced the response.
- busy  out  1: an operation is in flight (state is not IDLE).
- op_count  out  16: number of responses written since reset.

Behaviour:
- Reset (asynchronous, rst_n low):
  - State goes to IDLE.
  - alu_a, alu_b, alu_sel = 0.
  - FIFO is emptied: rsp_valid = 0, rsp_result = 0, rsp_carry = 0, rsp_sel = 0.
  - op_count = 0, busy = 0.
- Reset mid-operation: the in-flight command and all FIFO contents are discarded. No response is ever produced for them.
- FSM states: IDLE, SETTLE, CAPTURE.
  - IDLE: cmd_ready = 1 when FIFO count < RSP_DEPTH, else 0. A handshake (cmd_valid & cmd_ready at a rising edge) loads alu_a/alu_b/alu_sel from cmd_a/cmd_b/cmd_sel, loads settle counter = SETTLE-1, and moves to SETTLE.
  - SETTLE: cmd_ready = 0. The counter decrements each cycle. When the counter is 0, move to CAPTURE.
  - CAPTURE: cmd_ready = 0. At the rising edge, push {alu_sel, alu_carry, alu_out} into the FIFO, increment op_count, and return to IDLE.
- alu_a, alu_b and alu_sel hold their last command values in all states, including after capture. They change only on a new handshake or on reset.
- Latency:
  - Handshake at edge k, FIFO empty: rsp_valid rises after edge k+SETTLE+1.
  - Minimum command-to-command spacing is SETTLE+2 cycles.
- Only one command is in flight at a time, and acceptance requires a free FIFO slot, so a CAPTURE push never overflows.
- FIFO:
  - First-word fall-through: rsp_valid = not empty, with the head entry on the rsp_* outputs.
  - Pop on rsp_valid & rsp_ready.
  - Push and pop in the same cycle: count unchanged, order preserved.
  - Read and write pointers wrap modulo RSP_DEPTH.
- Full FIFO: cmd_ready stays 0 in IDLE until a pop occurs. cmd_ready rises in the cycle after the popping edge.
- Empty FIFO: rsp_ready is ignored and the rsp_* outputs hold their previous values.
- op_count wraps from 16'hFFFF to 16'h0000.
- The sequencer performs no arithmetic. Result values are exactly those the ALU produced while the registered inputs were stable.
- busy = (state != IDLE).

Test Plan:
- Reset behaviour: release rst_n, assert nothing -> alu_a/alu_b/alu_sel = 0, cmd_ready = 1, rsp_valid = 0, op_count = 0.
- Add with carry, SETTLE=1: cmd_a=8'hFF, cmd_b=8'h01, cmd_sel=4'b0000, accepted at edge k -> rsp_valid at edge k+2, rsp_result=8'h00, rsp_carry=1, rsp_sel=4'b0000, op_count=1.
- Rotate left: cmd_a=8'h0A, cmd_b=8'h05, cmd_sel=4'b0110 -> rsp_result=8'h14, rsp_sel=4'b0110. alu_a stays 8'h0A after the response.
- Backpressure, RSP_DEPTH=4, rsp_ready=0: issue 5 back-to-back commands -> 4 accepted, cmd_ready=0 with the 5th pending. Pulse rsp_ready one cycle -> cmd_ready rises the next cycle, the 5th is accepted, and responses drain in issue order.
- Simultaneous push and pop: rsp_ready=1 continuously, commands streamed at maximum rate -> FIFO count never exceeds 1, every result matches its command, op_count equals the number of commands.
- Reset mid-operation: assert rst_n low while in SETTLE with 2 entries queued -> rsp_valid=0 immediately. After release, op_count=0, alu_* = 0, and no stale response appears.
